// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mul_pkg;

   localparam int unsigned DEFAULT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

endpackage

// File: rtl/mul_step_counter.sv
// Step down-counter for the multiplier: loads WIDTH, decrements per CALC step,
// o_k flags the step that brings the count to zero.
module mul_step_counter
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_dec,
   output logic o_k
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= CW'(WIDTH);
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CW'(1);
      end
   end

   assign o_k = (r_cnt == CW'(1));

endmodule

// File: rtl/mul_seq_param.sv
// Parametrised sequential shift-add multiplier with signed/unsigned mode and busy/done handshake.
// Optional MUL_EARLY_TERM_EN: leave CALC as soon as the remaining multiplier bits are all zero.
module mul_seq_param
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   mndo,
   input  logic [WIDTH-1:0]   mdor,
   output logic [2*WIDTH-1:0] produto,
   output logic               busy,
   output logic               done
);

   state_t               r_state;
   state_t               w_next;
   logic                 r_sign;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   r_produto;
   logic [WIDTH-1:0]     r_mult;
   logic [WIDTH-1:0]     w_mndo_mag;
   logic [WIDTH-1:0]     w_mdor_mag;
   logic [WIDTH-1:0]     w_mult_shr;
   logic [2*WIDTH-1:0]   w_acc_add;
   logic                 w_accept;
   logic                 w_k;
   logic                 w_last;

   // Magnitude of the most-negative value wraps to itself, which is exact as unsigned.
   assign w_mndo_mag = (signed_mode && mndo[WIDTH-1]) ? -mndo : mndo;
   assign w_mdor_mag = (signed_mode && mdor[WIDTH-1]) ? -mdor : mdor;
   assign w_mult_shr = r_mult >> 1;
   assign w_acc_add  = r_mult[0] ? (r_acc + r_mcand) : r_acc;
   assign w_accept   = (r_state == IDLE) && start;

   mul_step_counter #(
      .WIDTH (WIDTH)
   ) u_step_counter (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_accept),
      .i_dec  (r_state == CALC),
      .o_k    (w_k)
   );

`ifdef MUL_EARLY_TERM_EN
   assign w_last = w_k || (w_mult_shr == '0);
`else
   assign w_last = w_k;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = CALC;
         CALC:    if (w_last) w_next = FIX;
         FIX:     w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == CALC) || (r_state == FIX);
      done = (r_state == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sign    <= 1'b0;
         r_mcand   <= '0;
         r_mult    <= '0;
         r_acc     <= '0;
         r_produto <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_sign  <= signed_mode & (mndo[WIDTH-1] ^ mdor[WIDTH-1]);
                  r_mcand <= {{WIDTH{1'b0}}, w_mndo_mag};
                  r_mult  <= w_mdor_mag;
                  r_acc   <= '0;
               end
            end
            CALC: begin
               r_acc   <= w_acc_add;
               r_mcand <= r_mcand << 1;
               r_mult  <= w_mult_shr;
            end
            FIX: begin
               r_produto <= r_sign ? -r_acc : r_acc;
            end
            default: ;
         endcase
      end
   end

   assign produto = r_produto;

endmodule
